adc_channel_scheduler: RTL and testbench

//  Owns the shared 2-channel 12-bit SPI ADC (MCP3202-style) that digitises both player sensors.

---
 rtl/game_pkg.sv | 19 +
 rtl/adc_channel_scheduler_spi.sv | 112 +++++++++++
 rtl/adc_channel_scheduler.sv | 101 ++++++++++
 tb/tb_adc_channel_scheduler.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the player-sensor ADC scheduler.
package game_pkg;

  localparam int ADC_W          = 12;
  localparam int FRAME_BITS     = 17;
  localparam int DATA_FIRST_BIT = 5;
  localparam int BIT_W          = $clog2(FRAME_BITS);

  typedef enum logic {CH_P1 = 1'b0, CH_P2 = 1'b1} adc_ch_t;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, UPDATE, WAIT} sched_state_t;

  // Command word sent MSB first: start, single-ended, channel, MSB-first; zeros afterwards.
  function automatic logic cmd_bit(input logic [BIT_W-1:0] k, input adc_ch_t ch);
    if (k == BIT_W'(2)) return logic'(ch);
    return (k < BIT_W'(4));
  endfunction

endpackage

// File: rtl/adc_channel_scheduler_spi.sv
// One MCP3202-style SPI frame: setup, 17 SCLK periods, then cs_n-high hold.
module spi_adc_frame
  import game_pkg::*;
#(
  parameter int CLK_DIV      = 4,
  parameter int CS_HIGH_CLKS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  adc_ch_t          ch,
  input  logic             adc_miso,
  output logic             adc_sclk,
  output logic             adc_mosi,
  output logic             adc_cs_n,
  output logic             phase_last,
  output logic [ADC_W-1:0] data
);

  localparam int CNT_MAX = (CLK_DIV > CS_HIGH_CLKS) ? CLK_DIV : CS_HIGH_CLKS;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0]    DIV_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0]    HOLD_LAST = CW'(CS_HIGH_CLKS - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0] BIT_DATA0 = BIT_W'(DATA_FIRST_BIT);

  typedef enum logic [1:0] {F_IDLE, F_SETUP, F_SHIFT, F_HOLD} frame_phase_t;

  frame_phase_t     phase, phase_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             half, half_nx;
  logic [BIT_W-1:0] bitk, bitk_nx;
  adc_ch_t          ch_q;
  logic             cs_n_nx, sclk_nx, mosi_nx, sample;

  always_ff @(posedge clk) begin
    if (!reset) begin
      phase    <= F_IDLE;
      cnt      <= '0;
      half     <= 1'b0;
      bitk     <= '0;
      ch_q     <= CH_P1;
      data     <= '0;
      adc_cs_n <= 1'b1;
      adc_sclk <= 1'b0;
      adc_mosi <= 1'b0;
    end else begin
      phase    <= phase_nx;
      cnt      <= cnt_nx;
      half     <= half_nx;
      bitk     <= bitk_nx;
      adc_cs_n <= cs_n_nx;
      adc_sclk <= sclk_nx;
      adc_mosi <= mosi_nx;
      if (start && phase == F_IDLE) ch_q <= ch;
      if (sample) data <= {data[ADC_W-2:0], adc_miso};
    end
  end

  // half=0 is the SCLK-low half of bit k, half=1 the high half.
  always_comb begin
    phase_nx   = phase;
    cnt_nx     = cnt + 1'b1;
    half_nx    = half;
    bitk_nx    = bitk;
    phase_last = 1'b0;
    case (phase)
      F_IDLE: begin
        cnt_nx  = '0;
        half_nx = 1'b0;
        bitk_nx = '0;
        if (start) phase_nx = F_SETUP;
      end
      F_SETUP: begin
        if (cnt == DIV_LAST) begin
          phase_last = 1'b1;
          phase_nx   = F_SHIFT;
          cnt_nx     = '0;
        end
      end
      F_SHIFT: begin
        if (cnt == DIV_LAST) begin
          cnt_nx  = '0;
          half_nx = ~half;
          if (half && bitk == BIT_LAST) begin
            phase_last = 1'b1;
            phase_nx   = F_HOLD;
          end else if (half) begin
            bitk_nx = bitk + 1'b1;
          end
        end
      end
      F_HOLD: begin
        if (cnt == HOLD_LAST) begin
          phase_last = 1'b1;
          phase_nx   = F_IDLE;
          cnt_nx     = '0;
        end
      end
      default: phase_nx = F_IDLE;
    endcase
  end

  // Pins are registered from the next phase so they change on the same edge as the phase.
  always_comb begin
    cs_n_nx = !(phase_nx == F_SETUP || phase_nx == F_SHIFT);
    sclk_nx = (phase_nx == F_SHIFT) && half_nx;
    mosi_nx = (phase_nx == F_SETUP) || ((phase_nx == F_SHIFT) && cmd_bit(bitk_nx, ch_q));
    sample  = (phase == F_SHIFT) && !half && (cnt == DIV_LAST) && (bitk >= BIT_DATA0);
  end

endmodule

// File: rtl/adc_channel_scheduler.sv
// Schedules ADC conversions for one or two players and holds the latest result per player.
module adc_channel_scheduler
  import game_pkg::*;
#(
  parameter int CLK_DIV       = 4,
  parameter int CS_HIGH_CLKS  = 8,
  parameter int SAMPLE_PERIOD = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             multi,
  input  logic             adc_miso,
  output logic             adc_sclk,
  output logic             adc_mosi,
  output logic             adc_cs_n,
  output logic [ADC_W-1:0] p1data,
  output logic [ADC_W-1:0] p2data,
  output logic             p1_valid,
  output logic             p2_valid,
  output logic             busy,
  output sched_state_t     dbg_state
);

  localparam int PW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(SAMPLE_PERIOD - 1);

  sched_state_t     state, state_nx;
  adc_ch_t          ch;
  logic [PW-1:0]    pcnt;
  logic             start, do_update, phase_last;
  logic [ADC_W-1:0] frame_data;

  spi_adc_frame #(
    .CLK_DIV      (CLK_DIV),
    .CS_HIGH_CLKS (CS_HIGH_CLKS)
  ) u_frame (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .ch         (ch),
    .adc_miso   (adc_miso),
    .adc_sclk   (adc_sclk),
    .adc_mosi   (adc_mosi),
    .adc_cs_n   (adc_cs_n),
    .phase_last (phase_last),
    .data       (frame_data)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (en) state_nx = SETUP;
      SETUP:   if (phase_last) state_nx = SHIFT;
      SHIFT:   if (phase_last) state_nx = HOLD;
      HOLD:    if (phase_last) state_nx = UPDATE;
      UPDATE:  state_nx = WAIT;
      WAIT: begin
        if (!en)                 state_nx = IDLE;
        else if (pcnt == P_LAST) state_nx = SETUP;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == SETUP) || (state == SHIFT) || (state == HOLD) || (state == UPDATE);
    start     = (state == IDLE || state == WAIT) && (state_nx == SETUP);
    do_update = (state == UPDATE);
  end

  // The period counter saturates so an overlong frame just leaves WAIT after one clock.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pcnt     <= '0;
      ch       <= CH_P1;
      p1data   <= '0;
      p2data   <= '0;
      p1_valid <= 1'b0;
      p2_valid <= 1'b0;
    end else begin
      if (start)               pcnt <= '0;
      else if (pcnt != P_LAST) pcnt <= pcnt + 1'b1;
      p1_valid <= do_update && (ch == CH_P1);
      p2_valid <= do_update && (ch == CH_P2);
      if (do_update) begin
        if (ch == CH_P1) p1data <= frame_data;
        else             p2data <= frame_data;
        ch <= multi ? adc_ch_t'(~ch) : CH_P1;
      end
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_adc_channel_scheduler.sv
// Directed bench: default-period instance plus a short-period instance, each with an ADC model.
module tb_adc_channel_scheduler;
  import game_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, en_a, multi_a, miso_a, sclk_a, mosi_a, cs_a, v1_a, v2_a, busy_a;
  logic [11:0] p1_a, p2_a;
  sched_state_t st_a;
  logic rst_b, en_b, multi_b, miso_b, sclk_b, mosi_b, cs_b, v1_b, v2_b, busy_b;
  logic [11:0] p1_b, p2_b;
  sched_state_t st_b;

  adc_channel_scheduler u_dut (
    .clk(clk), .reset(rst_a), .en(en_a), .multi(multi_a), .adc_miso(miso_a),
    .adc_sclk(sclk_a), .adc_mosi(mosi_a), .adc_cs_n(cs_a), .p1data(p1_a), .p2data(p2_a),
    .p1_valid(v1_a), .p2_valid(v2_a), .busy(busy_a), .dbg_state(st_a)
  );

  adc_channel_scheduler #(.SAMPLE_PERIOD(50)) u_dut_b2b (
    .clk(clk), .reset(rst_b), .en(en_b), .multi(multi_b), .adc_miso(miso_b),
    .adc_sclk(sclk_b), .adc_mosi(mosi_b), .adc_cs_n(cs_b), .p1data(p1_b), .p2data(p2_b),
    .p1_valid(v1_b), .p2_valid(v2_b), .busy(busy_b), .dbg_state(st_b)
  );

  // ADC models: capture command bits on SCLK rise, shift result out on SCLK fall.
  int ra = 0, rb = 0;
  logic [3:0]  cmd_a = '0, cmd_b = '0;
  logic [11:0] word_a, word_b;
  initial begin miso_a = 1'b0; miso_b = 1'b0; end

  always @(negedge cs_a) begin ra = 0; cmd_a = '0; end
  always @(posedge sclk_a) begin if (ra < 4) cmd_a[3-ra] = mosi_a; ra = ra + 1; end
  always @(negedge sclk_a) begin
    word_a = cmd_a[1] ? 12'h3F1 : 12'hA5C;
    if (ra >= 5 && ra <= 16) miso_a = word_a[16-ra];
    else miso_a = 1'b0;
  end

  always @(negedge cs_b) begin rb = 0; cmd_b = '0; end
  always @(posedge sclk_b) begin if (rb < 4) cmd_b[3-rb] = mosi_b; rb = rb + 1; end
  always @(negedge sclk_b) begin
    word_b = cmd_b[1] ? 12'h3F1 : 12'hA5C;
    if (rb >= 5 && rb <= 16) miso_b = word_b[16-rb];
    else miso_b = 1'b0;
  end

  // Event monitor, sampled 1 time unit after each rising edge.
  int cyc = 0;
  int fall_a = 0, t_fall_a = 0, nv1_a = 0, nv2_a = 0, t_v_a = 0, lv_a = 0, both_a = 0;
  int fall_b = 0, t_fall_b = 0, prev_t_fall_b = 0, run_b = 0, hi_run_b = 0;
  int nv1_b = 0, nv2_b = 0, both_b = 0;
  logic prev_cs_a = 1'b1, prev_cs_b = 1'b1;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (prev_cs_a && !cs_a) begin fall_a++; t_fall_a = cyc; end
    prev_cs_a = cs_a;
    if (v1_a) begin nv1_a++; t_v_a = cyc; lv_a = 1; end
    if (v2_a) begin nv2_a++; t_v_a = cyc; lv_a = 2; end
    if (v1_a && v2_a) both_a++;
    if (cs_b) run_b++;
    if (prev_cs_b && !cs_b) begin
      fall_b++; prev_t_fall_b = t_fall_b; t_fall_b = cyc; hi_run_b = run_b; run_b = 0;
    end
    prev_cs_b = cs_b;
    if (v1_b) nv1_b++;
    if (v2_b) nv2_b++;
    if (v1_b && v2_b) both_b++;
  end

  int n_chk = 0, n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int ev(input int w);
    case (w)
      0:       return fall_a;
      1:       return nv1_a + nv2_a;
      2:       return fall_b;
      default: return nv1_b + nv2_b;
    endcase
  endfunction

  task automatic wait_ev(input int w, input int target, input int budget, input string tag);
    int k = 0;
    while (ev(w) < target && k < budget) begin @(negedge clk); k++; end
    if (ev(w) < target) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  int t_prev;

  initial begin
    rst_a = 1'b0; en_a = 1'b0; multi_a = 1'b0;
    rst_b = 1'b0; en_b = 1'b0; multi_b = 1'b0;
    tick(3);
    check("rst_cs_n",  32'(cs_a),   32'd1);
    check("rst_sclk",  32'(sclk_a), 32'd0);
    check("rst_mosi",  32'(mosi_a), 32'd0);
    check("rst_p1",    32'(p1_a),   32'd0);
    check("rst_p2",    32'(p2_a),   32'd0);
    check("rst_v1",    32'(v1_a),   32'd0);
    check("rst_v2",    32'(v2_a),   32'd0);
    check("rst_busy",  32'(busy_a), 32'd0);
    check("rst_state", 32'(st_a),   32'(IDLE));

    // single player: ch0 frames 1000 clocks apart
    rst_a = 1'b1; en_a = 1'b1;
    wait_ev(0, 1, 50, "f1_start");
    wait_ev(1, 1, 300, "f1_valid");
    check("f1_latency", t_v_a - t_fall_a, 149);
    check("f1_ch",      lv_a, 1);
    check("f1_p1data",  32'(p1_a), 32'h0A5C);
    check("f1_p2data",  32'(p2_a), 32'd0);
    check("f1_cmd",     32'(cmd_a), 32'b1101);
    check("f1_state",   32'(st_a), 32'(WAIT));
    check("f1_busy",    32'(busy_a), 32'd0);
    t_prev = t_v_a;
    wait_ev(1, 2, 1100, "f2_valid");
    check("f2_period", t_v_a - t_prev, 1000);
    check("f2_ch",     lv_a, 1);
    check("f2_cmd",    32'(cmd_a), 32'b1101);

    // multiplayer: the frame in flight is still ch0, then ch1
    multi_a = 1'b1;
    wait_ev(1, 3, 1100, "f3_valid");
    check("f3_ch", lv_a, 1);
    t_prev = t_v_a;
    wait_ev(1, 4, 1100, "f4_valid");
    check("f4_ch",      lv_a, 2);
    check("f4_period",  t_v_a - t_prev, 1000);
    check("f4_p2data",  32'(p2_a), 32'h03F1);
    check("f4_p1data",  32'(p1_a), 32'h0A5C);
    check("f4_cmd",     32'(cmd_a), 32'b1111);

    // multi dropped during a ch0 frame: next frame stays ch0
    wait_ev(0, 5, 1100, "f5_start");
    multi_a = 1'b0;
    wait_ev(1, 5, 300, "f5_valid");
    check("f5_ch", lv_a, 1);
    wait_ev(1, 6, 1100, "f6_valid");
    check("f6_ch",     lv_a, 1);
    check("f6_cmd",    32'(cmd_a), 32'b1101);
    check("f6_p2data", 32'(p2_a), 32'h03F1);
    check("f6_nv2",    nv2_a, 1);

    // en dropped around SHIFT bit 8: frame completes, then idle
    wait_ev(0, 7, 1100, "f7_start");
    tick(70);
    en_a = 1'b0;
    wait_ev(1, 7, 300, "f7_valid");
    check("f7_ch", lv_a, 1);
    tick(3);
    check("f7_state", 32'(st_a), 32'(IDLE));
    check("f7_busy",  32'(busy_a), 32'd0);
    check("f7_cs_n",  32'(cs_a), 32'd1);
    tick(1200);
    check("idle_frames", fall_a, 7);
    check("idle_valids", nv1_a + nv2_a, 7);

    // reset mid-SHIFT aborts the frame
    en_a = 1'b1;
    wait_ev(0, 8, 50, "f8_start");
    tick(50);
    rst_a = 1'b0;
    tick(1);
    check("abort_cs_n", 32'(cs_a), 32'd1);
    check("abort_sclk", 32'(sclk_a), 32'd0);
    tick(2);
    check("abort_p1",    32'(p1_a), 32'd0);
    check("abort_p2",    32'(p2_a), 32'd0);
    check("abort_state", 32'(st_a), 32'(IDLE));
    check("abort_busy",  32'(busy_a), 32'd0);
    en_a = 1'b0; rst_a = 1'b1;
    tick(20);
    check("abort_valids", nv1_a + nv2_a, 7);
    check("abort_idle_cs", 32'(cs_a), 32'd1);

    // short period: back-to-back frames
    rst_b = 1'b1; en_b = 1'b1; multi_b = 1'b1;
    wait_ev(2, 3, 600, "b_start3");
    check("b_cs_high",  hi_run_b, 10);
    check("b_period",   t_fall_b - prev_t_fall_b, 150);
    check("b_nv1",      nv1_b, 1);
    check("b_nv2",      nv2_b, 1);
    check("b_p1data",   32'(p1_b), 32'h0A5C);
    check("b_p2data",   32'(p2_b), 32'h03F1);
    en_b = 1'b0;

    check("a_never_both", both_a, 0);
    check("b_never_both", both_b, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
